coeff2bram: RTL

- Writer side of the coefficient BRAM path.
- Accepts a stream of 25 signed filter coefficients from the host/config logic and writes them into port A of the coefficient dual-port BRAM.
- Double-buffered in two BRAM banks; the bank holding the newly written set becomes the read bank only on the next vs_i rising edge.
- The BRAM-to-coefficient reader uses coeff_bank as its address MSB, so the filter never sees a half-updated set mid-frame.

---
 rtl/fir_coeff_pkg.sv | 21 ++
 rtl/vs_edge_det.sv | 19 +
 rtl/coeff2bram.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fir_coeff_pkg.sv
// Constants and FSM encoding shared by the coefficient BRAM writer and reader.
package fir_coeff_pkg;

  localparam int NUM_COEFF = 25;
  localparam int COEFF_W   = 16;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 6;
  localparam int BANK_BIT  = ADDR_W - 1;
  localparam int IDX_W     = BANK_BIT;
  localparam int SUM_W     = 21;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    DRAIN   = 2'd2,
    WAIT_VS = 2'd3
  } coeff_state_e;

endpackage

// File: rtl/vs_edge_det.sv
// Registers vs_i and flags its rising edge combinationally against the registered copy.
module vs_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vs_i,
  output logic vs_rise
);

  logic vs_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vs_q <= 1'b0;
    else     vs_q <= vs_i;
  end

  assign vs_rise = vs_i & ~vs_q;

endmodule

// File: rtl/coeff2bram.sv
// Writes a 25-coefficient set into the inactive BRAM bank and swaps banks on the next vs_i rise.
// Optional feature: define COEFF_SUM_EN to report the signed sum of the active set on coeff_sum.
module coeff2bram
  import fir_coeff_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COEFF_W-1:0]      s_coeff_data,
  input  logic                    s_coeff_valid,
  input  logic                    s_coeff_last,
  output logic                    s_coeff_ready,
  input  logic                    vs_i,
  output logic                    bram_we,
  output logic [ADDR_W-1:0]       bram_addr,
  output logic [DATA_W-1:0]       bram_din,
  output logic                    coeff_bank,
  output logic                    set_done,
  output logic                    err_len,
  output logic signed [SUM_W-1:0] coeff_sum
);

  coeff_state_e     state_q, state_d;
  logic [IDX_W-1:0] index_q;
  logic [IDX_W-1:0] beat_idx;
  logic             accept;
  logic             vs_rise;
  logic             wr_beat;
  logic             first_beat;
  logic             err_d;
  logic             swap;

  vs_edge_det u_vs_edge (
    .clk     (clk),
    .rst     (rst),
    .vs_i    (vs_i),
    .vs_rise (vs_rise)
  );

  // Ready is held low while reset is asserted so every output reads 0 during reset.
  assign s_coeff_ready = ~rst & (state_q != WAIT_VS);
  assign accept        = s_coeff_valid & s_coeff_ready;
  assign beat_idx      = (state_q == IDLE) ? '0 : index_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    wr_beat    = 1'b0;
    first_beat = 1'b0;
    err_d      = 1'b0;
    swap       = 1'b0;
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          wr_beat    = 1'b1;
          first_beat = (state_q == IDLE);
          if (s_coeff_last) begin
            if (beat_idx == LAST_IDX) begin
              state_d = WAIT_VS;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else if (beat_idx == LAST_IDX) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = LOAD;
          end
        end
      end
      DRAIN: begin
        if (accept && s_coeff_last) state_d = IDLE;
      end
      WAIT_VS: begin
        // The edge register has already absorbed any rise seen with the final beat.
        if (vs_rise) begin
          swap    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      index_q    <= '0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      coeff_bank <= 1'b0;
      set_done   <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bram_we  <= wr_beat;
      set_done <= swap;
      err_len  <= err_d;
      if (wr_beat) begin
        index_q   <= beat_idx + 1'b1;
        bram_addr <= {~coeff_bank, beat_idx};
        bram_din  <= {{(DATA_W-COEFF_W){s_coeff_data[COEFF_W-1]}}, s_coeff_data};
      end
      if (swap) coeff_bank <= ~coeff_bank;
    end
  end

`ifdef COEFF_SUM_EN
  logic signed [SUM_W-1:0] acc_q;
  logic signed [SUM_W-1:0] coeff_ext;

  assign coeff_ext = {{(SUM_W-COEFF_W){s_coeff_data[COEFF_W-1]}}, s_coeff_data};

  // The accumulator restarts on each first beat, so an aborted set never reaches coeff_sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      coeff_sum <= '0;
    end else begin
      if (wr_beat) acc_q <= first_beat ? coeff_ext : acc_q + coeff_ext;
      if (swap)    coeff_sum <= acc_q;
    end
  end
`else
  assign coeff_sum = '0;
`endif

endmodule
